// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART responder.
// Register offsets relative to BASE_ADDR, CON bit positions, and the
// state encoding used by both the transmit and receive state machines.
package uart_mmio_pkg;

  localparam logic [31:0] OFF_TXD = 32'h0000_0000;
  localparam logic [31:0] OFF_RXD = 32'h0000_0004;
  localparam logic [31:0] OFF_CON = 32'h0000_0008;

  localparam int CON_TX_IRQ_EN = 0;
  localparam int CON_RX_IRQ_EN = 1;
  localparam int CON_TX_DONE   = 2;
  localparam int CON_RX_VALID  = 3;
  localparam int CON_TX_BUSY   = 4;
  localparam int CON_RX_OVR    = 5;
  localparam int CON_FRAME_ERR = 6;
  localparam int CON_TX_DROP   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, start detection, centre sampling of 8N1.
// byte_valid/frame_err are single-cycle pulses on the stop-bit sample edge.
// No backpressure: the register file decides whether a byte is kept or dropped.
module uart_rx_core
  import uart_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic       byte_valid,
  output logic [7:0] data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync;
  logic          rx_s;
  logic          rx_prev;
  uart_state_t   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shift, shift_next;

  assign rx_s = sync[1];
  assign data = shift;

  // Synchronise the asynchronous line (idle high) and keep one delayed copy
  // so a start is only recognised on a genuine high-to-low transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], rx_in};
      rx_prev <= rx_s;
    end
  end

  // Receiver state, baud counter, bit index and assembled byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
    end
  end

  // Next-state logic. After a framing error the line is usually still low,
  // so requiring a falling edge in IDLE also waits for the line to recover.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt + 1'b1;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    byte_valid   = 1'b0;
    frame_err    = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (rx_prev && !rx_s) state_next = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift[7:1]};
          bit_idx_next = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
          byte_valid = rx_s;
          frame_err  = !rx_s;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_mmio_responder.sv
// Memory-mapped UART: TXD/RXD/CON registers, TX serialiser, level interrupt.
// Reads are zero-wait combinational; first start-bit edge 1 cycle after a TXD write.
// TXD writes while busy are dropped and flagged; received bytes overrun when unread.
module uart_mmio_responder
  import uart_mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 2604,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        UART_RX,
  output logic        UART_TX,
  output logic        irqout
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [31:0] TXD_ADDR = BASE_ADDR + OFF_TXD;
  localparam logic [31:0] RXD_ADDR = BASE_ADDR + OFF_RXD;
  localparam logic [31:0] CON_ADDR = BASE_ADDR + OFF_CON;

  logic sel_txd, sel_rxd, sel_con;
  logic txd_wr, con_wr, rxd_rd;
  logic tx_accept, tx_busy, tx_finish;

  uart_state_t   tx_state, tx_state_next;
  logic [CW-1:0] tx_cnt, tx_cnt_next;
  logic [2:0]    tx_bit, tx_bit_next;
  logic          tx_line, tx_line_next;

  logic [7:0] tx_byte;
  logic [7:0] rx_data;
  logic       tx_irq_en, rx_irq_en;
  logic       tx_done, rx_valid, rx_overrun, st_frame_err, tx_drop;
  logic [7:0] con;

  logic       rx_byte_vld;
  logic [7:0] rx_byte;
  logic       rx_ferr;

  // Byte lanes and sub-word address bits carry no meaning for these registers.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  assign sel_txd   = (addr[31:2] == TXD_ADDR[31:2]);
  assign sel_rxd   = (addr[31:2] == RXD_ADDR[31:2]);
  assign sel_con   = (addr[31:2] == CON_ADDR[31:2]);
  assign txd_wr    = wr & sel_txd;
  assign con_wr    = wr & sel_con;
  assign rxd_rd    = rd & sel_rxd;
  assign tx_busy   = (tx_state != IDLE);
  assign tx_accept = txd_wr & ~tx_busy;
  assign UART_TX   = tx_line;

  assign con = {tx_drop, st_frame_err, rx_overrun, tx_busy,
                rx_valid, tx_done, rx_irq_en, tx_irq_en};

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (UART_RX),
    .byte_valid (rx_byte_vld),
    .data       (rx_byte),
    .frame_err  (rx_ferr)
  );

  // Transmitter state and the registered line driver (idle high on reset).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_next;
      tx_cnt   <= tx_cnt_next;
      tx_bit   <= tx_bit_next;
      tx_line  <= tx_line_next;
    end
  end

  // Transmitter sequencing: each state spans one bit time; the data bit comes
  // straight from the held TXD byte, which cannot change while busy.
  always_comb begin
    tx_state_next = tx_state;
    tx_cnt_next   = tx_cnt + 1'b1;
    tx_bit_next   = tx_bit;
    tx_line_next  = tx_line;
    tx_finish     = 1'b0;
    case (tx_state)
      IDLE: begin
        tx_cnt_next = '0;
        if (tx_accept) begin
          tx_state_next = START;
          tx_line_next  = 1'b0;
        end
      end
      START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
          tx_state_next = DATA;
          tx_line_next  = tx_byte[0];
        end
      end
      DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_next = '0;
          if (tx_bit == 3'd7) begin
            tx_state_next = STOP;
            tx_line_next  = 1'b1;
          end else begin
            tx_bit_next  = tx_bit + 1'b1;
            tx_line_next = tx_byte[tx_bit + 3'd1];
          end
        end
      end
      STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_state_next = IDLE;
          tx_finish     = 1'b1;
        end
      end
      default: tx_state_next = IDLE;
    endcase
  end

  // Register file: W1C status bits with hardware set taking priority over the
  // clear, receive hand-off where a new byte beats a simultaneous RXD read,
  // and the interrupt level registered from the current status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_byte      <= '0;
      rx_data      <= '0;
      tx_irq_en    <= 1'b0;
      rx_irq_en    <= 1'b0;
      tx_done      <= 1'b0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      st_frame_err <= 1'b0;
      tx_drop      <= 1'b0;
      irqout       <= 1'b0;
    end else begin
      if (tx_accept) tx_byte <= wdata[7:0];
      if (con_wr) begin
        tx_irq_en <= wdata[CON_TX_IRQ_EN];
        rx_irq_en <= wdata[CON_RX_IRQ_EN];
      end
      tx_done      <= (tx_done & ~(con_wr & wdata[CON_TX_DONE])) | tx_finish;
      tx_drop      <= (tx_drop & ~(con_wr & wdata[CON_TX_DROP])) | (txd_wr & tx_busy);
      st_frame_err <= (st_frame_err & ~(con_wr & wdata[CON_FRAME_ERR])) | rx_ferr;
      rx_overrun   <= (rx_overrun & ~(con_wr & wdata[CON_RX_OVR]))
                    | (rx_byte_vld & rx_valid & ~rxd_rd);
      if (rx_byte_vld && (!rx_valid || rxd_rd)) begin
        rx_data  <= rx_byte;
        rx_valid <= 1'b1;
      end else if (rxd_rd) begin
        rx_valid <= 1'b0;
      end
      irqout <= (tx_irq_en & tx_done) | (rx_irq_en & rx_valid);
    end
  end

  // Zero-wait read mux; anything other than a mapped read returns zero.
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_txd)      rdata = {24'b0, tx_byte};
      else if (sel_rxd) rdata = {24'b0, rx_data};
      else if (sel_con) rdata = {24'b0, con};
    end
  end

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Directed-plus-random bench for the UART MMIO responder at CLKS_PER_BIT=8.
// Expected register contents come from a small event-level model of the
// register map; serial frames are built as {stop, byte, start} vectors.
module tb_uart_mmio_responder;

  localparam int          N    = 8;
  localparam logic [31:0] BASE = 32'h4000_0018;
  localparam logic [31:0] TXD  = BASE;
  localparam logic [31:0] RXD  = BASE + 32'd4;
  localparam logic [31:0] CON  = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        UART_RX = 1'b1;
  logic        UART_TX;
  logic        irqout;

  int tests = 0;
  int fails = 0;

  // Reference model of the software-visible state.
  bit       m_txen, m_rxen, m_txdone, m_rxv, m_ovr, m_ferr, m_drop;
  bit [7:0] m_rxd, m_txd;

  uart_mmio_responder #(.CLKS_PER_BIT(N), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .UART_RX (UART_RX),
    .UART_TX (UART_TX),
    .irqout  (irqout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    {m_txen, m_rxen, m_txdone, m_rxv, m_ovr, m_ferr, m_drop} = '0;
    m_rxd = '0;
    m_txd = '0;
  endtask

  function automatic logic [31:0] con_exp(input bit busy);
    return {24'b0, m_drop, m_ferr, m_ovr, busy, m_rxv, m_txdone, m_rxen, m_txen};
  endfunction

  function automatic logic [31:0] irq_exp();
    return {31'b0, (m_txen & m_txdone) | (m_rxen & m_rxv)};
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  // Read without letting a clock edge see the strobe.
  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    #1;
    d = rdata;
    rd = 1'b0; addr = '0;
  endtask

  // Read whose strobe is sampled by one clock edge (side effects apply).
  task automatic read_commit(input logic [31:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    #1;
    d = rdata;
    @(posedge clk);
    #1;
    rd = 1'b0; addr = '0;
  endtask

  task automatic con_write(input logic [7:0] d);
    bus_write(CON, {24'b0, d});
    m_txen = d[0];
    m_rxen = d[1];
    if (d[2]) m_txdone = 1'b0;
    if (d[5]) m_ovr = 1'b0;
    if (d[6]) m_ferr = 1'b0;
    if (d[7]) m_drop = 1'b0;
  endtask

  // Send one byte and check the line at the centre of every bit; optionally
  // attempt a second TXD write mid-frame, which must be dropped.
  task automatic tx_frame_check(input logic [7:0] b, input bit do_drop, input logic [7:0] drop_val);
    logic [9:0]  fr;
    logic [31:0] d;
    fr = {1'b1, b, 1'b0};
    bus_write(TXD, {24'b0, b});
    m_txd = b;
    check("tx_start_edge", {31'b0, UART_TX}, 32'd0);
    for (int j = 0; j < 10; j++) begin
      repeat (N / 2) tick();
      check($sformatf("tx_bit%0d", j), {31'b0, UART_TX}, {31'b0, fr[j]});
      if (j == 5) begin
        peek(CON, d);
        check("con_in_frame", d, con_exp(1'b1));
      end
      if (do_drop && j == 2) begin
        bus_write(TXD, {24'b0, drop_val});
        m_drop = 1'b1;
        repeat (N / 2 - 1) tick();
      end else begin
        repeat (N / 2) tick();
      end
    end
    m_txdone = 1'b1;
    peek(CON, d);
    check("con_after_frame", d, con_exp(1'b0));
    peek(TXD, d);
    check("txd_read", d, {24'b0, m_txd});
  endtask

  task automatic rx_head(input logic [7:0] b);
    UART_RX = 1'b0;
    repeat (N) tick();
    for (int k = 0; k < 8; k++) begin
      UART_RX = b[k];
      repeat (N) tick();
    end
  endtask

  task automatic rx_frame(input logic [7:0] b, input bit stop);
    rx_head(b);
    UART_RX = stop;
    repeat (N) tick();
    UART_RX = 1'b1;
    repeat (2 * N) tick();
    if (!stop) m_ferr = 1'b1;
    else if (!m_rxv) begin
      m_rxd = b;
      m_rxv = 1'b1;
    end else m_ovr = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    bit          seen;

    model_reset();
    repeat (3) tick();
    check("reset_tx", {31'b0, UART_TX}, 32'd1);
    check("reset_irq", {31'b0, irqout}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    peek(CON, d);
    check("reset_con", d, con_exp(1'b0));
    reset = 1'b0;
    tick();

    // Basic transmit with interrupts disabled.
    tx_frame_check(8'hA5, 1'b0, 8'h00);
    check("tx_irq_off", {31'b0, irqout}, irq_exp());

    // Write while busy is dropped; tx_done from the previous frame remains.
    tx_frame_check(8'h11, 1'b1, 8'h22);
    con_write(8'h84);
    peek(CON, d);
    check("con_cleared", d, con_exp(1'b0));

    // Transmit-complete interrupt and its W1C clear.
    con_write(8'h01);
    tx_frame_check(8'($urandom), 1'b0, 8'h00);
    tick();
    check("tx_irq_on", {31'b0, irqout}, 32'd1);
    con_write(8'h05);
    tick();
    check("tx_irq_clr", {31'b0, irqout}, irq_exp());
    con_write(8'h00);

    // Receive 0x3C with rx interrupt enabled; watch rx_valid then irqout.
    con_write(8'h02);
    rx_head(8'h3C);
    UART_RX = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3 * N && !seen; i++) begin
      tick();
      peek(CON, d);
      seen = d[3];
    end
    check("rx_valid_seen", {31'b0, seen}, 32'd1);
    check("rx_irq_lag", {31'b0, irqout}, 32'd0);
    m_rxd = 8'h3C;
    m_rxv = 1'b1;
    tick();
    check("rx_irq_on", {31'b0, irqout}, 32'd1);
    read_commit(RXD, d);
    check("rxd_3c", d, 32'h0000_003C);
    m_rxv = 1'b0;
    peek(CON, d);
    check("rx_valid_clr", d, con_exp(1'b0));
    tick();
    check("rx_irq_clr", {31'b0, irqout}, irq_exp());
    repeat (2 * N) tick();

    // Overrun: second byte lost, first kept.
    rx_frame(8'h01, 1'b1);
    rx_frame(8'h02, 1'b1);
    peek(RXD, d);
    check("ovr_rxd", d, {24'b0, m_rxd});
    peek(CON, d);
    check("ovr_con", d, con_exp(1'b0));
    check("ovr_irq", {31'b0, irqout}, irq_exp());
    con_write(8'h20);
    peek(CON, d);
    check("ovr_clr", d, con_exp(1'b0));
    read_commit(RXD, d);
    check("ovr_rxd_read", d, 32'h0000_0001);
    m_rxv = 1'b0;

    // Stop bit held low: no byte, framing error.
    rx_frame(8'h5A, 1'b0);
    peek(CON, d);
    check("ferr_con", d, con_exp(1'b0));
    con_write(8'h40);

    // Short low glitch must not start a frame or set any flag.
    UART_RX = 1'b0;
    repeat (2) tick();
    UART_RX = 1'b1;
    repeat (2 * N) tick();
    peek(CON, d);
    check("glitch_con", d, con_exp(1'b0));
    b = 8'($urandom);
    rx_frame(b, 1'b1);
    read_commit(RXD, d);
    check("post_glitch_rxd", d, {24'b0, b});
    m_rxv = 1'b0;

    // Randomised mix of transmit and receive traffic.
    for (int r = 0; r < 4; r++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        tx_frame_check(b, 1'b0, 8'h00);
        con_write(8'h04);
      end else begin
        rx_frame(b, 1'b1);
        read_commit(RXD, d);
        check($sformatf("rand_rxd%0d", r), d, {24'b0, b});
        m_rxv = 1'b0;
      end
    end

    // Reset 30 cycles into a frame, then a fresh complete frame.
    bus_write(TXD, 32'h0000_00F0);
    repeat (29) tick();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_mid_tx", {31'b0, UART_TX}, 32'd1);
    peek(CON, d);
    check("rst_mid_con", d, con_exp(1'b0));
    check("rst_mid_irq", {31'b0, irqout}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tx_frame_check(8'($urandom), 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
